sram_arbiter: RTL

//  Shares the single external 1Mx16 SRAM between two requesters: the SLC-3 CPU memory port
//  (cpu_*) and the program loader (ldr_*). Sequences every access through

---
 rtl/sram_arb_pkg.sv | 27 ++
 rtl/sram_arb_rr.sv | 35 +++
 rtl/sram_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and strobe levels for the two-requester external SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_LDR = 1'b1
    } req_id_t;

    // SRAM strobes are active-low
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam int WAIT_W = 4;

    // Round-robin tie-break: whoever was not served last wins
    function automatic req_id_t rr_other(input req_id_t last_id);
        return (last_id == REQ_CPU) ? REQ_LDR : REQ_CPU;
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker: bit 0 is the CPU request, bit 1 the loader request.
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last_grant,
    output req_id_t    o_grant,
    output logic       o_valid
);

    // Pick a single winner; a tie goes to whoever was not granted last
    always_comb begin
        o_grant = REQ_CPU;
        o_valid = 1'b0;
        case (i_req)
            2'b01: begin
                o_grant = REQ_CPU;
                o_valid = 1'b1;
            end
            2'b10: begin
                o_grant = REQ_LDR;
                o_valid = 1'b1;
            end
            2'b11: begin
                o_grant = rr_other(i_last_grant);
                o_valid = 1'b1;
            end
            default: begin
                o_grant = REQ_CPU;
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external async SRAM between the CPU memory port and the program loader,
// sequencing each access as SETUP / ACCESS / DONE with registered active-low strobes.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM
);

    generate
        if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
            $error("sram_arbiter: WAIT_CYCLES must lie in 1..15");
        end
    endgenerate

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

    arb_state_t        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    req_id_t           r_id;
    req_id_t           r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ce;
    logic              r_ub;
    logic              r_lb;
    logic              r_oe;
    logic              r_we_n;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic              r_cpu_ack;
    logic              r_ldr_ack;

    req_id_t           w_grant;
    logic              w_grant_valid;
    logic              w_grant_we;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_grant_wdata;

    sram_arb_rr u_rr (
        .i_req        ({ldr_req, cpu_req}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_grant_valid)
    );

    // Route the winning requester's command toward the latch registers
    always_comb begin
        w_grant_we    = cpu_we;
        w_grant_addr  = cpu_addr;
        w_grant_wdata = cpu_wdata;
        if (w_grant == REQ_LDR) begin
            w_grant_we    = ldr_we;
            w_grant_addr  = ldr_addr;
            w_grant_wdata = ldr_wdata;
        end else begin
            w_grant_we    = cpu_we;
            w_grant_addr  = cpu_addr;
            w_grant_wdata = cpu_wdata;
        end
    end

    // Access sequencer; every strobe is computed one edge ahead so outputs stay registered
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= {WAIT_W{1'b0}};
            r_id         <= REQ_CPU;
            r_last_grant <= REQ_LDR;
            r_we         <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_ce         <= STROBE_OFF;
            r_ub         <= STROBE_OFF;
            r_lb         <= STROBE_OFF;
            r_oe         <= STROBE_OFF;
            r_we_n       <= STROBE_OFF;
            r_cpu_rdata  <= {DATA_W{1'b0}};
            r_ldr_rdata  <= {DATA_W{1'b0}};
            r_cpu_ack    <= 1'b0;
            r_ldr_ack    <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ldr_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_state      <= S_SETUP;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_we         <= w_grant_we;
                        r_addr       <= w_grant_addr;
                        r_wdata      <= w_grant_wdata;
                        r_ce         <= STROBE_ON;
                        r_ub         <= STROBE_ON;
                        r_lb         <= STROBE_ON;
                        r_oe         <= w_grant_we ? STROBE_OFF : STROBE_ON;
                        r_we_n       <= STROBE_OFF;
                    end
                end
                S_SETUP: begin
                    // WE only falls after the address has been stable for a full cycle
                    r_state    <= S_ACCESS;
                    r_wait_cnt <= WAIT_LAST;
                    r_we_n     <= r_we ? STROBE_ON : STROBE_OFF;
                end
                S_ACCESS: begin
                    if (r_wait_cnt == {WAIT_W{1'b0}}) begin
                        r_state <= S_DONE;
                        r_ce    <= STROBE_OFF;
                        r_ub    <= STROBE_OFF;
                        r_lb    <= STROBE_OFF;
                        r_oe    <= STROBE_OFF;
                        r_we_n  <= STROBE_OFF;
                        if (r_id == REQ_CPU) begin
                            r_cpu_ack <= 1'b1;
                            if (!r_we) begin
                                r_cpu_rdata <= Data_from_SRAM;
                            end
                        end else begin
                            r_ldr_ack <= 1'b1;
                            if (!r_we) begin
                                r_ldr_rdata <= Data_from_SRAM;
                            end
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ce    <= STROBE_OFF;
                    r_ub    <= STROBE_OFF;
                    r_lb    <= STROBE_OFF;
                    r_oe    <= STROBE_OFF;
                    r_we_n  <= STROBE_OFF;
                end
            endcase
        end
    end

    assign Mem_CE       = r_ce;
    assign Mem_UB       = r_ub;
    assign Mem_LB       = r_lb;
    assign Mem_OE       = r_oe;
    assign Mem_WE       = r_we_n;
    assign ADDR         = r_addr;
    assign Data_to_SRAM = r_wdata;
    assign cpu_rdata    = r_cpu_rdata;
    assign ldr_rdata    = r_ldr_rdata;
    assign cpu_ack      = r_cpu_ack;
    assign ldr_ack      = r_ldr_ack;

endmodule
